// File: rtl/emu_step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : emu_step_ctrl_pkg
// Brief    : Shared state encoding for the fixed-timestep emulator sequencer.
// Revision : 1.0  initial release
// ============================================================================
package emu_step_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_RST_HOLD = 3'd1,
    ST_PRIME    = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_SAMPLE   = 3'd4,
    ST_STEP     = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/emu_step_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : emu_step_ctrl_if
// Brief    : Command, model-control and sample-stream bundle of the sequencer.
//            master = sequencer side, slave = host/model side.
// Revision : 1.0  initial release
// ============================================================================
interface emu_step_ctrl_if #(
  parameter int STEP_W = 16,
  parameter int SMP_W  = 18
) ();

  logic              cmd_start;
  logic [STEP_W-1:0] cmd_num_steps;
  logic              cmd_abort;
  logic              go;
  logic              model_rst;
  logic [SMP_W-1:0]  v_out;
  logic              smp_valid;
  logic              smp_ready;
  logic [SMP_W-1:0]  smp_data;
  logic [STEP_W-1:0] smp_idx;
  logic              busy;
  logic              done;

  modport master (
    input  cmd_start, cmd_num_steps, cmd_abort, v_out, smp_ready,
    output go, model_rst, smp_valid, smp_data, smp_idx, busy, done
  );

  modport slave (
    output cmd_start, cmd_num_steps, cmd_abort, v_out, smp_ready,
    input  go, model_rst, smp_valid, smp_data, smp_idx, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/emu_win_check.sv
`default_nettype none
// ============================================================================
// Module   : emu_win_check
// Brief    : Signed window compare on accepted samples with a saturating
//            error counter and a sticky error flag.
// Revision : 1.0  initial release
// ============================================================================
module emu_win_check #(
  parameter int STEP_W = 16,
  parameter int SMP_W  = 18
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              clr,
  input  wire logic              fire,
  input  wire logic [SMP_W-1:0]  sample,
  input  wire logic [SMP_W-1:0]  lo,
  input  wire logic [SMP_W-1:0]  hi,
  output logic      [STEP_W-1:0] err_cnt,
  output logic                   err
);

  logic outside;
  assign outside = ($signed(sample) < $signed(lo)) || ($signed(sample) > $signed(hi));

  // Count out-of-window samples at the moment they are handed over; saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      err     <= 1'b0;
    end else if (clr) begin
      err_cnt <= '0;
      err     <= 1'b0;
    end else if (fire && outside) begin
      err <= 1'b1;
      if (err_cnt != {STEP_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/emu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : emu_step_ctrl
// Brief    : On-chip reset/prime/step/sample sequencer for a fixed-timestep
//            analog model. Issues single-cycle go pulses and streams the model
//            output captured after every step over a valid/ready channel.
//            Optional feature macro: EMU_STEP_CTRL_CHECK_EN adds a signed
//            window checker (chk_lo/chk_hi in, err_cnt/err out).
// Revision : 1.0  initial release
// ============================================================================
module emu_step_ctrl
  import emu_step_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 16,
  parameter int STEP_W     = 16,
  parameter int SMP_W      = 18
) (
  input  wire logic        emu_clk,
  input  wire logic        emu_rst,
  emu_step_ctrl_if.master  bus
`ifdef EMU_STEP_CTRL_CHECK_EN
  ,
  input  wire logic [SMP_W-1:0]  chk_lo,
  input  wire logic [SMP_W-1:0]  chk_hi,
  output logic      [STEP_W-1:0] err_cnt,
  output logic                   err
`endif
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t            state, state_nxt;
  logic [STEP_W-1:0] n_steps;
  logic [CNT_W-1:0]  hold_cnt;
  logic [SMP_W-1:0]  data_q;
  logic [STEP_W-1:0] idx_q;

  logic go, model_rst, smp_valid, busy, done;
  logic start_acc, last_step, hs;

  // Abort has priority over start when both arrive together in IDLE.
  assign start_acc = (state == ST_IDLE) && bus.cmd_start && !bus.cmd_abort;
  assign last_step = (idx_q == n_steps - 1'b1);
  assign hs        = smp_valid && bus.smp_ready;

  // State register.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and Moore outputs; the model is held in reset whenever no step is in flight.
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    model_rst = 1'b1;
    smp_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_acc) state_nxt = (bus.cmd_num_steps == '0) ? ST_DONE : ST_RST_HOLD;
      end
      ST_RST_HOLD: begin
        if (hold_cnt == '0) state_nxt = ST_PRIME;
      end
      ST_PRIME: begin
        go        = 1'b1;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        model_rst = 1'b0;
        state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        model_rst = 1'b0;
        smp_valid = 1'b1;
        if (bus.smp_ready) state_nxt = ST_STEP;
      end
      ST_STEP: begin
        model_rst = 1'b0;
        go        = 1'b1;
        state_nxt = last_step ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if ((state != ST_IDLE) && bus.cmd_abort) state_nxt = ST_IDLE;
  end

  // Run datapath: step count, reset-hold counter, captured sample and its index.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      n_steps  <= '0;
      hold_cnt <= '0;
      data_q   <= '0;
      idx_q    <= '0;
    end else begin
      if (start_acc) begin
        n_steps  <= bus.cmd_num_steps;
        hold_cnt <= CNT_W'(RST_CYCLES - 1);
        idx_q    <= '0;
      end
      if ((state == ST_RST_HOLD) && (hold_cnt != '0)) hold_cnt <= hold_cnt - 1'b1;
      if (state == ST_SETTLE) data_q <= bus.v_out;
      if ((state == ST_STEP) && !last_step && !bus.cmd_abort) idx_q <= idx_q + 1'b1;
    end
  end

  assign bus.go        = go;
  assign bus.model_rst = model_rst;
  assign bus.smp_valid = smp_valid;
  assign bus.smp_data  = data_q;
  assign bus.smp_idx   = idx_q;
  assign bus.busy      = busy;
  assign bus.done      = done;

`ifdef EMU_STEP_CTRL_CHECK_EN
  emu_win_check #(
    .STEP_W (STEP_W),
    .SMP_W  (SMP_W)
  ) u_win_check (
    .clk     (emu_clk),
    .rst     (emu_rst),
    .clr     (start_acc),
    .fire    (hs),
    .sample  (data_q),
    .lo      (chk_lo),
    .hi      (chk_hi),
    .err_cnt (err_cnt),
    .err     (err)
  );
`else
  // Handshake only feeds the window checker.
  logic hs_unused;
  assign hs_unused = hs;
`endif

endmodule
`default_nettype wire
